// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the bit-serial ALU: operation codes, FSM state
//   encoding and small helpers describing how each operation uses the carry
//   path.
//
//   Operation codes (3 bits):
//     000 ADD   001 AND   010 OR   011 XOR   100 XNOR   101 SUB
//     110, 111  reserved -> result 0, carry out 0
//
//   SUB is computed as A + ~B + 1: operand B is inverted when it is latched
//   and the serial carry is seeded with 1, so the slice adds in both cases.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] MODE_ADD  = 3'b000;
  localparam logic [2:0] MODE_AND  = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_XOR  = 3'b011;
  localparam logic [2:0] MODE_XNOR = 3'b100;
  localparam logic [2:0] MODE_SUB  = 3'b101;

  // Encoded state values kept as plain constants so older code that compares
  // raw 2-bit state words still lines up with the enum below.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_RUN  = ST_RUN_ENC,
    S_DONE = ST_DONE_ENC
  } state_e;

  // ADD and SUB are the only operations that propagate a carry.
  function automatic logic mode_is_arith(input logic [2:0] mode);
    return (mode == MODE_ADD) || (mode == MODE_SUB);
  endfunction

  // Codes 110/111 produce an all-zero result with no carry.
  function automatic logic mode_is_reserved(input logic [2:0] mode);
    return (mode == 3'b110) || (mode == 3'b111);
  endfunction

  // Initial carry: the "+1" of the two's-complement subtraction.
  function automatic logic mode_carry_init(input logic [2:0] mode);
    return (mode == MODE_SUB);
  endfunction

  // Operand B as presented to the serial datapath (inverted for SUB).
  function automatic logic mode_invert_b(input logic [2:0] mode);
    return (mode == MODE_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// -----------------------------------------------------------------------------
// alu_slice
//   Combinational 1-bit ALU slice. Processes one bit position per call:
//   full adder for ADD/SUB, bitwise gates for the logic operations.
//
//   Ports:
//     mode  in  [2:0]  operation code (alu_pkg MODE_*)
//     a     in         operand A bit
//     b     in         operand B bit (already inverted by the caller for SUB)
//     cin   in         carry in (1 on the first SUB bit, else previous cout)
//     x     out        result bit
//     cout  out        carry out; forced 0 for every non-arithmetic mode
// -----------------------------------------------------------------------------
module alu_slice
  import alu_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       x,
  output logic       cout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;

  always_comb begin
    x    = 1'b0;
    cout = 1'b0;
    case (mode)
      MODE_ADD,
      MODE_SUB: begin
        x    = a_xor_b ^ cin;
        cout = (a & b) | (cin & a_xor_b);
      end
      MODE_AND:  x = a & b;
      MODE_OR:   x = a | b;
      MODE_XOR:  x = a_xor_b;
      MODE_XNOR: x = ~a_xor_b;
      default: begin
        // reserved codes: result and carry stay 0
        x    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// -----------------------------------------------------------------------------
// alu_serial
//   Bit-serial ALU. WIDTH-bit operands are processed LSB first, one bit per
//   clock, through a single alu_slice with a registered carry. A start/done
//   handshake frames each operation; the published result registers only
//   change on the final RUN edge, so a partial result is never visible.
//
//   Parameters:
//     WIDTH   operand/result width, legal range 2..32
//
//   Ports:
//     clk     in               system clock, rising edge
//     rst_n   in               asynchronous active-low reset
//     start   in               request; sampled only in IDLE or DONE
//     mode    in  [2:0]        operation code, latched with the operands
//     a       in  [WIDTH-1:0]  operand A
//     b       in  [WIDTH-1:0]  operand B
//     busy    out              high while in RUN
//     done    out              one-cycle pulse when x/c_out/zero are new
//     x       out [WIDTH-1:0]  result register
//     c_out   out              ADD carry / SUB not-borrow / else 0
//     zero    out              x == 0
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; result registers hold last values
//   S_RUN  | one bit per clock through the slice, cnt counts 0..WIDTH-1
//   S_DONE | result just published, done high; start accepted again here
//
//   Latency: start seen at edge 0 -> done high after edge WIDTH.
// -----------------------------------------------------------------------------
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic             c_out,
  output logic             zero
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  state_e             state_d;

  logic [2:0]         mode_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  // Holds bits already produced; the newest bit enters at the top and the
  // full word is assembled combinationally on the last edge.
  logic [WIDTH-2:0]   res_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   x_q;
  logic               c_out_q;
  logic               zero_q;

  logic               slice_x;
  logic               slice_cout;
  logic [WIDTH-1:0]   res_next;

  logic               accept;
  logic               in_run;
  logic               last_bit;

  alu_slice u_slice (
    .mode (mode_q),
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .x    (slice_x),
    .cout (slice_cout)
  );

  assign in_run   = (state_q == S_RUN);
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = in_run && (cnt_q == CNT_LAST);
  assign res_next = {slice_x, res_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch and serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_ADD;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      mode_q  <= mode;
      op_a_q  <= a;
      op_b_q  <= mode_invert_b(mode) ? ~b : b;
      res_q   <= '0;
      carry_q <= mode_carry_init(mode);
      cnt_q   <= '0;
    end else if (in_run) begin
      op_a_q  <= op_a_q >> 1;
      op_b_q  <= op_b_q >> 1;
      res_q   <= res_next[WIDTH-1:1];
      // the slice already forces cout to 0 for logic and reserved codes
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Published result: touched only on the final RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (last_bit) begin
      x_q     <= res_next;
      c_out_q <= mode_is_arith(mode_q) ? slice_cout : 1'b0;
      zero_q  <= (res_next == '0);
    end
  end

  assign busy  = in_run;
  assign done  = (state_q == S_DONE);
  assign x     = x_q;
  assign c_out = c_out_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// -----------------------------------------------------------------------------
// tb_alu_serial
//   Three alu_serial instances (WIDTH 8, 16, 2) share clock and reset. A
//   behavioural model computes each result with plain integer arithmetic
//   when a start is accepted and releases it WIDTH clocks later. Every
//   falling edge all DUT outputs are compared against the model; directed
//   operations additionally compare against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_alu_serial;

  localparam int NI = 3;
  localparam int W0 = 8;
  localparam int W1 = 16;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic [NI-1:0]        start_v;
  logic [NI-1:0][2:0]   mode_v;
  logic [NI-1:0][31:0]  a_v;
  logic [NI-1:0][31:0]  b_v;
  logic [NI-1:0]        busy_v;
  logic [NI-1:0]        done_v;
  logic [NI-1:0]        c_v;
  logic [NI-1:0]        z_v;
  logic [W0-1:0]        x0;
  logic [W1-1:0]        x1;
  logic [W2-1:0]        x2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(W0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]),
    .a(a_v[0][W0-1:0]), .b(b_v[0][W0-1:0]), .busy(busy_v[0]),
    .done(done_v[0]), .x(x0), .c_out(c_v[0]), .zero(z_v[0])
  );

  alu_serial #(.WIDTH(W1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]),
    .a(a_v[1][W1-1:0]), .b(b_v[1][W1-1:0]), .busy(busy_v[1]),
    .done(done_v[1]), .x(x1), .c_out(c_v[1]), .zero(z_v[1])
  );

  alu_serial #(.WIDTH(W2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]),
    .a(a_v[2][W2-1:0]), .b(b_v[2][W2-1:0]), .busy(busy_v[2]),
    .done(done_v[2]), .x(x2), .c_out(c_v[2]), .zero(z_v[2])
  );

  function automatic int wid(input int i);
    return (i == 0) ? W0 : (i == 1) ? W1 : W2;
  endfunction

  function automatic logic [31:0] get_x(input int i);
    case (i)
      0:       return 32'(x0);
      1:       return 32'(x1);
      default: return 32'(x2);
    endcase
  endfunction

  // Reference result {carry, value} from integer arithmetic.
  function automatic logic [32:0] model_op(input int w, input logic [2:0] md,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] s;
    logic        c;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'd0, a} & m;
    bb = {32'd0, b} & m;
    case (md)
      3'd0:    s = aa + bb;
      3'd5:    s = aa + (~bb & m) + 64'd1;
      3'd1:    s = aa & bb;
      3'd2:    s = aa | bb;
      3'd3:    s = aa ^ bb;
      3'd4:    s = ~(aa ^ bb) & m;
      default: s = 64'd0;
    endcase
    c = ((md == 3'd0) || (md == 3'd5)) ? s[w] : 1'b0;
    return {c, 32'(s & m)};
  endfunction

  // Behavioural model: an op is accepted when not busy, its result appears
  // WIDTH clocks later together with a one-cycle done.
  logic [NI-1:0]        m_busy;
  logic [NI-1:0]        m_done;
  logic [NI-1:0]        m_c;
  logic [NI-1:0]        m_z;
  logic [NI-1:0][31:0]  m_x;
  logic [NI-1:0][32:0]  m_pend;
  int                   m_rem [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0;
      m_done <= '0;
      m_c    <= '0;
      m_z    <= '1;
      m_x    <= '0;
      m_pend <= '0;
      for (int i = 0; i < NI; i++) m_rem[i] <= 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_busy[i]) begin
          m_rem[i] <= m_rem[i] - 1;
          if (m_rem[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_x[i]    <= m_pend[i][31:0];
            m_c[i]    <= m_pend[i][32];
            m_z[i]    <= (m_pend[i][31:0] == 32'd0);
          end
        end else begin
          m_done[i] <= 1'b0;
          if (start_v[i]) begin
            m_pend[i] <= model_op(wid(i), mode_v[i], a_v[i], b_v[i]);
            m_busy[i] <= 1'b1;
            m_rem[i]  <= wid(i);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("w%0d busy", wid(i)), 32'(busy_v[i]), 32'(m_busy[i]));
      check($sformatf("w%0d done", wid(i)), 32'(done_v[i]), 32'(m_done[i]));
      check($sformatf("w%0d x", wid(i)), get_x(i), m_x[i]);
      check($sformatf("w%0d c_out", wid(i)), 32'(c_v[i]), 32'(m_c[i]));
      check($sformatf("w%0d zero", wid(i)), 32'(z_v[i]), 32'(m_z[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  // Waits (bounded) for done on instance i; lat counts falling edges seen.
  task automatic wait_done(input int i, inout int lat, inout int nbusy);
    while (!done_v[i] && lat < 100) begin
      tick();
      lat++;
      if (busy_v[i]) nbusy++;
    end
    check($sformatf("w%0d done timeout", wid(i)), 32'(done_v[i]), 32'd1);
  endtask

  task automatic do_op(input int i, input logic [2:0] md, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int nbusy);
    start_v[i] = 1'b1;
    mode_v[i]  = md;
    a_v[i]     = a;
    b_v[i]     = b;
    lat   = 0;
    nbusy = 0;
    tick();
    lat++;
    if (busy_v[i]) nbusy++;
    start_v[i] = 1'b0;
    wait_done(i, lat, nbusy);
  endtask

  typedef struct {
    int          i;
    logic [2:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ex;
    logic        ec;
  } lit_t;

  lit_t lits[$];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int nbusy;

    start_v = '0;
    mode_v  = '0;
    a_v     = '0;
    b_v     = '0;
    rst_n   = 1'b0;

    // W8
    lits.push_back('{0, 3'b000, 32'h7F,   32'h01,   32'h80,   1'b0});
    lits.push_back('{0, 3'b000, 32'hFF,   32'h01,   32'h00,   1'b1});
    lits.push_back('{0, 3'b101, 32'h05,   32'h07,   32'hFE,   1'b0});
    lits.push_back('{0, 3'b101, 32'h07,   32'h05,   32'h02,   1'b1});
    lits.push_back('{0, 3'b001, 32'hA5,   32'h3C,   32'h24,   1'b0});
    lits.push_back('{0, 3'b010, 32'hA5,   32'h3C,   32'hBD,   1'b0});
    lits.push_back('{0, 3'b011, 32'hA5,   32'h3C,   32'h99,   1'b0});
    lits.push_back('{0, 3'b100, 32'hA5,   32'h3C,   32'h66,   1'b0});
    lits.push_back('{0, 3'b110, 32'hA5,   32'h3C,   32'h00,   1'b0});
    lits.push_back('{0, 3'b111, 32'hFF,   32'hFF,   32'h00,   1'b0});
    // W16
    lits.push_back('{1, 3'b000, 32'hFFFF, 32'h0001, 32'h0000, 1'b1});
    lits.push_back('{1, 3'b000, 32'h7FFF, 32'h0001, 32'h8000, 1'b0});
    lits.push_back('{1, 3'b101, 32'h0005, 32'h0007, 32'hFFFE, 1'b0});
    lits.push_back('{1, 3'b001, 32'hA5A5, 32'h3C3C, 32'h2424, 1'b0});
    lits.push_back('{1, 3'b100, 32'hA5A5, 32'h3C3C, 32'h6666, 1'b0});
    lits.push_back('{1, 3'b110, 32'hA5A5, 32'h3C3C, 32'h0000, 1'b0});
    // W2
    lits.push_back('{2, 3'b000, 32'h3,    32'h1,    32'h0,    1'b1});
    lits.push_back('{2, 3'b000, 32'h1,    32'h1,    32'h2,    1'b0});
    lits.push_back('{2, 3'b101, 32'h1,    32'h2,    32'h3,    1'b0});
    lits.push_back('{2, 3'b101, 32'h2,    32'h1,    32'h1,    1'b1});
    lits.push_back('{2, 3'b001, 32'h2,    32'h3,    32'h2,    1'b0});
    lits.push_back('{2, 3'b010, 32'h1,    32'h2,    32'h3,    1'b0});
    lits.push_back('{2, 3'b011, 32'h3,    32'h1,    32'h2,    1'b0});
    lits.push_back('{2, 3'b100, 32'h3,    32'h1,    32'h1,    1'b0});
    lits.push_back('{2, 3'b110, 32'h3,    32'h3,    32'h0,    1'b0});

    // reset state
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("w%0d reset x", wid(i)), get_x(i), 32'd0);
      check($sformatf("w%0d reset zero", wid(i)), 32'(z_v[i]), 32'd1);
      check($sformatf("w%0d reset busy", wid(i)), 32'(busy_v[i]), 32'd0);
      check($sformatf("w%0d reset done", wid(i)), 32'(done_v[i]), 32'd0);
      check($sformatf("w%0d reset c_out", wid(i)), 32'(c_v[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // directed operations with literal results and latency
    foreach (lits[k]) begin
      do_op(lits[k].i, lits[k].md, lits[k].a, lits[k].b, lat, nbusy);
      check($sformatf("lit%0d x", k), get_x(lits[k].i), lits[k].ex);
      check($sformatf("lit%0d c_out", k), 32'(c_v[lits[k].i]), 32'(lits[k].ec));
      check($sformatf("lit%0d zero", k), 32'(z_v[lits[k].i]), 32'(lits[k].ex == 32'd0));
      check($sformatf("lit%0d latency", k), 32'(lat), 32'(wid(lits[k].i) + 1));
      check($sformatf("lit%0d busy cycles", k), 32'(nbusy), 32'(wid(lits[k].i)));
      tick();
    end

    // start during RUN is ignored; start in DONE chains with no idle gap
    start_v[0] = 1'b1; mode_v[0] = 3'b000; a_v[0] = 32'h10; b_v[0] = 32'h20;
    lat = 0; nbusy = 0;
    tick(); lat++;
    start_v[0] = 1'b0;
    tick(); tick(); lat += 2;
    start_v[0] = 1'b1; mode_v[0] = 3'b101; a_v[0] = 32'hFF; b_v[0] = 32'hFF;
    tick(); lat++;
    start_v[0] = 1'b0;
    wait_done(0, lat, nbusy);
    check("ignored start x", get_x(0), 32'h30);
    check("ignored start latency", 32'(lat), 32'(W0 + 1));
    start_v[0] = 1'b1; mode_v[0] = 3'b000; a_v[0] = 32'h01; b_v[0] = 32'h02;
    lat = 0; nbusy = 0;
    tick(); lat++;
    check("chained busy", 32'(busy_v[0]), 32'd1);
    start_v[0] = 1'b0;
    wait_done(0, lat, nbusy);
    check("chained x", get_x(0), 32'h03);
    check("chained latency", 32'(lat), 32'(W0 + 1));
    tick();

    // async reset in the middle of RUN
    start_v[0] = 1'b1; mode_v[0] = 3'b000; a_v[0] = 32'h11; b_v[0] = 32'h22;
    tick();
    start_v[0] = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrun reset x", get_x(0), 32'd0);
    check("midrun reset busy", 32'(busy_v[0]), 32'd0);
    check("midrun reset done", 32'(done_v[0]), 32'd0);
    check("midrun reset zero", 32'(z_v[0]), 32'd1);
    check("midrun reset c_out", 32'(c_v[0]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_op(0, 3'b000, 32'h03, 32'h04, lat, nbusy);
    check("post reset add x", get_x(0), 32'h07);
    check("post reset add latency", 32'(lat), 32'(W0 + 1));

    // random traffic on all widths, including starts while busy
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < NI; i++) begin
        start_v[i] = ($urandom_range(0, 2) == 0);
        mode_v[i]  = 3'($urandom_range(0, 7));
        a_v[i]     = pick();
        b_v[i]     = pick();
      end
      tick();
      if (k == 1500) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    start_v = '0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
Parametrised bit-serial ALU: WIDTH-bit operands processed LSB-first, one bit per clock, through a single 1-bit ALU slice with a registered carry.
- Adds a start/done handshake, result and flag registers, and a SUB mode on top of the existing 1-bit ADD/AND/OR/XOR/XNOR slice.
- Sits between the control sequencer and the register file as the area-minimal datapath ALU.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE or DONE state
MODE  input  3  operation code, latched on accepted START
A  input  WIDTH  operand A, latched on accepted START
B  input  WIDTH  operand B, latched on accepted START
BUSY  output  1  high while in RUN
DONE  output  1  one-cycle pulse: X/C_OUT/ZERO newly valid
X  output  WIDTH  result register
C_OUT  output  1  carry out (ADD), NOT-borrow (SUB), else 0
ZERO  output  1  X == 0

Behaviour:
- Interface: one clock, CLK. Reset RST_N is asynchronous, active-low.
- Reset (async, any state including mid-RUN):
  - state=IDLE.
  - BUSY=0, DONE=0, X=0, C_OUT=0, ZERO=1.
  - Internal shift registers, bit counter and carry cleared.
  - No partial result is ever published.
- MODE encoding: 000 ADD, 001 AND, 010 OR, 011 XOR, 100 XNOR, 101 SUB (A + ~B + 1).
  - 110 and 111 are reserved: result 0, C_OUT=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: START=1 -> latch A, B, MODE; init carry (1 for SUB, else 0); cnt=0; go to RUN.
  - RUN: each cycle the slice processes opA[0], opB'[0] (B inverted for SUB) and carry.
    - Sum/logic bit shifts into the MSB of the result shift register.
    - opA/opB shift right; carry register updates (ADD/SUB only; forced 0 otherwise); cnt++.
    - When cnt==WIDTH-1, transfer to X, C_OUT and ZERO happens on the same edge; go to DONE.
  - DONE: DONE=1 for exactly one cycle.
    - START=1 -> accepted as in IDLE, back-to-back into RUN.
    - Otherwise go to IDLE.
- Latency: START sampled at edge 0 -> DONE high in the cycle after edge WIDTH; WIDTH+1 cycles start-to-done. Throughput is one op per WIDTH+1 cycles.
- START while BUSY is ignored; in-flight operands are unaffected.
- X, C_OUT and ZERO hold their last values during RUN and IDLE. They change only at the RUN->DONE edge.
- C_OUT is the final carry of the MSB stage:
  - SUB: C_OUT=1 means no borrow (A>=B unsigned).
  - Logic/reserved modes: C_OUT=0.
- Counter width is $clog2(WIDTH). No wrap occurs because the FSM leaves RUN at WIDTH-1.

Decomposition:
- Package alu_pkg holds:
  - MODE_ADD..MODE_SUB localparams and the reserved-code handling rule.
  - State enum {IDLE, RUN, DONE}.
- Sub-module alu_slice: combinational 1-bit slice.
  - Inputs: mode, a, b, cin. Outputs: x, cout.
  - Covers ADD/SUB (SUB via pre-inverted b and cin=1) and AND/OR/XOR/XNOR; cout=0 outside ADD/SUB.
  - Instantiated once.

Test Plan:
1. WIDTH=8, ADD A=8'h7F B=8'h01, START 1 cycle -> BUSY 8 cycles, DONE pulse at cycle 9, X=8'h80, C_OUT=0, ZERO=0.
2. ADD A=8'hFF B=8'h01 -> X=8'h00, C_OUT=1, ZERO=1. SUB A=8'h05 B=8'h07 -> X=8'hFE, C_OUT=0. SUB A=8'h07 B=8'h05 -> X=8'h02, C_OUT=1.
3. Logic ops on A=8'hA5 B=8'h3C -> AND 8'h24, OR 8'hBD, XOR 8'h99, XNOR 8'h66; C_OUT=0 for each. MODE=3'b110 -> X=0, ZERO=1.
4. START re-asserted with new operands during RUN -> ignored; first result unchanged. START held during DONE cycle -> next op starts with no IDLE gap, DONE again WIDTH+1 cycles later.
5. RST_N pulled low at cycle 4 of RUN (asynchronously, between edges) -> outputs immediately X=0, BUSY=0, DONE=0, ZERO=1. After release, a new ADD 8'h03+8'h04 yields 8'h07.
6. Repeat tests 1-3 with WIDTH=16 and WIDTH=2, e.g. 16'hFFFF+16'h0001 -> X=0, C_OUT=1, latency 17 cycles.
